demux_2_32_buf: RTL and testbench
=================================

DEMUX_2_32_BUF -- requirements
Module: demux_2_32_buf

Interface
REQ-001 The block SHALL have parameter word_size, default 32, giving the data width of all data ports.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port data_in, input, word_size, the word offered by the upstream 2:1 mux / bus driver.
REQ-005 The block SHALL have port in_valid, input, 1, meaning data_in and in_sel are valid this cycle.
REQ-006 The block SHALL have port in_sel, input, 1, selecting the destination: 1 routes to channel 1, 0 to channel 0.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the selected channel can accept a word this cycle.
REQ-008 The block SHALL have ports data_0 and data_1, output, word_size, the head word of channel 0 and channel 1.
REQ-009 The block SHALL have ports valid_0 and valid_1, output, 1, meaning the matching channel head word is valid.
REQ-010 The block SHALL have ports ready_0 and ready_1, input, 1, the downstream consumer accepts the matching channel head.
REQ-011 The block SHALL have port busy, output, 1, high while either channel holds at least one word.

Function
REQ-012 Each channel SHALL be a 2-entry FIFO with a 1-bit write pointer, a 1-bit read pointer and a 2-bit count in the range 0..2.
REQ-013 in_ready SHALL be combinational: high when the count of the channel chosen by in_sel is below 2, independent of that channel's ready_x.
REQ-014 A push SHALL occur on a rising edge with in_valid and in_ready both high; data_in is written to the selected channel only.
REQ-015 Upstream SHALL hold data_in and in_sel stable while in_valid is high and in_ready is low; the block does not check this.
REQ-016 valid_x SHALL equal (count_x != 0), and data_x SHALL present the entry at that channel's read pointer.
REQ-017 A pop SHALL occur on a rising edge with valid_x and ready_x both high; the read pointer advances and wraps 1 to 0.
REQ-018 Latency SHALL be one cycle: a word pushed at edge N is visible on data_x with valid_x high after edge N.
REQ-019 Simultaneous push and pop on the same channel SHALL leave the count unchanged; both pointers advance.
REQ-020 When full (count 2), a simultaneous pop SHALL NOT make in_ready high in the same cycle; the push is accepted on the next cycle.
REQ-021 A pop with count 0, or a push with in_ready low, SHALL change no state.
REQ-022 A push to one channel SHALL NOT block or reorder the other channel; words within one channel leave in arrival order.
REQ-023 busy SHALL equal valid_0 OR valid_1.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear both counts and all pointers, forcing valid_0, valid_1 and busy to 0 without waiting for clk.
REQ-025 During reset, data_0 and data_1 SHALL read 0 and in_ready SHALL read 1.
REQ-026 Reset mid-transfer SHALL discard all buffered words; the first push after release is the first word seen downstream.
REQ-027 Deassertion of rst_n SHALL be sampled so that no push or pop occurs on the edge coincident with release.

Configuration
REQ-028 With macro DEMUX_TRISTATE_OUT_EN defined, data_x SHALL be driven to all-z whenever valid_x is 0, so both channels may share a bus with other drivers.
REQ-029 Without DEMUX_TRISTATE_OUT_EN, data_x SHALL hold the last popped entry's storage value, which is 0 after reset, when valid_x is 0.

Verification
REQ-030 Reset then push 32'hA5A5_0001 with in_sel=0 -> valid_0=1, data_0=32'hA5A5_0001 next cycle; valid_1 stays 0.
REQ-031 Hold ready_1=0 and push 3 words with in_sel=1 -> first two accepted, in_ready=0 on the third; raise ready_1 -> the words drain in order and the third is then accepted.
REQ-032 Channel 0 full at count 2 with ready_0=1 and in_valid=1, in_sel=0 -> pop only in that cycle (count 1), push on the next.
REQ-033 Count 1 with push and pop in the same cycle -> count stays 1, data_0 shows the next word; pointer wrap checked over 6 words.
REQ-034 Pull rst_n low asynchronously between edges with both channels full -> valid_0=valid_1=busy=0 before the next clk edge.
REQ-035 Define DEMUX_TRISTATE_OUT_EN, empty channel -> data_0 = 32'hzzzz_zzzz; undefined -> data_0 = 32'h0000_0000 after reset.

Source files
------------

// File: rtl/demux_2_32_buf.sv
// demux_2_32_buf: 1-to-2 demultiplexer with a 2-entry FIFO on each output channel.
// in_sel steers each accepted word into channel 0 or channel 1. Each channel then
// drains on its own valid/ready handshake.
// Optional macro DEMUX_TRISTATE_OUT_EN: an empty channel drives its data port to all-z,
// so it can share a bus. Without the macro, the data port holds the last popped word.
module demux_2_32_buf #(
  parameter int unsigned word_size = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [word_size-1:0] data_in,
  input  logic                 in_valid,
  input  logic                 in_sel,
  output logic                 in_ready,
  output logic [word_size-1:0] data_0,
  output logic [word_size-1:0] data_1,
  output logic                 valid_0,
  output logic                 valid_1,
  input  logic                 ready_0,
  input  logic                 ready_1,
  output logic                 busy
);

  localparam int unsigned NCH   = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  logic [word_size-1:0] mem_q  [NCH][DEPTH];
  logic [word_size-1:0] mem_d  [NCH][DEPTH];
  logic [word_size-1:0] last_q [NCH];
  logic [word_size-1:0] last_d [NCH];
  logic [word_size-1:0] head_c [NCH];
  logic [CW-1:0]        count_q [NCH];
  logic [CW-1:0]        count_d [NCH];
  logic [NCH-1:0]       wr_ptr_q, wr_ptr_d;
  logic [NCH-1:0]       rd_ptr_q, rd_ptr_d;
  logic [NCH-1:0]       push_c, pop_c, valid_c, ready_dn_c;
  logic                 rst_meta_q, run_q;

  // Reset release synchronizer: no push or pop until release has been sampled twice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      run_q      <= rst_meta_q;
    end
  end

  // Acceptance depends only on the selected channel's occupancy, never on its downstream ready
  always_comb begin
    in_ready = (count_q[in_sel] < CW'(DEPTH));
  end

  // Per-channel handshakes and head-of-queue view
  always_comb begin
    ready_dn_c = {ready_1, ready_0};
    push_c     = '0;
    pop_c      = '0;
    valid_c    = '0;
    for (int ch = 0; ch < int'(NCH); ch++) begin
      valid_c[ch] = (count_q[ch] != '0);
      head_c[ch]  = mem_q[ch][rd_ptr_q[ch]];
      push_c[ch]  = run_q && in_valid && in_ready && (in_sel == 1'(ch));
      pop_c[ch]   = run_q && valid_c[ch] && ready_dn_c[ch];
    end
  end

  // Next-state for storage, pointers, occupancy and last-popped word
  always_comb begin
    mem_d    = mem_q;
    last_d   = last_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int ch = 0; ch < int'(NCH); ch++) begin
      if (push_c[ch]) begin
        mem_d[ch][wr_ptr_q[ch]] = data_in;
        wr_ptr_d[ch]            = ~wr_ptr_q[ch];
      end
      if (pop_c[ch]) begin
        last_d[ch]   = head_c[ch];
        rd_ptr_d[ch] = ~rd_ptr_q[ch];
      end
      count_d[ch] = count_q[ch] + CW'(push_c[ch]) - CW'(pop_c[ch]);
    end
  end

  // State registers; reset discards every buffered word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < int'(NCH); ch++) begin
        for (int e = 0; e < int'(DEPTH); e++) begin
          mem_q[ch][e] <= '0;
        end
        last_q[ch]  <= '0;
        count_q[ch] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      last_q   <= last_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign valid_0 = valid_c[0];
  assign valid_1 = valid_c[1];
  assign busy    = valid_c[0] | valid_c[1];

`ifdef DEMUX_TRISTATE_OUT_EN
  // An empty channel releases the shared bus
  assign data_0 = valid_c[0] ? head_c[0] : {word_size{1'bz}};
  assign data_1 = valid_c[1] ? head_c[1] : {word_size{1'bz}};
`else
  // An empty channel holds the last word it delivered
  assign data_0 = valid_c[0] ? head_c[0] : last_q[0];
  assign data_1 = valid_c[1] ? head_c[1] : last_q[1];
`endif

endmodule

// File: tb/tb_demux_2_32_buf.sv
// Directed testbench for demux_2_32_buf. The expected values are worked out by hand.
module tb_demux_2_32_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        in_valid, in_sel, in_ready;
  logic [31:0] data_0, data_1;
  logic        valid_0, valid_1, ready_0, ready_1, busy;

  int tests = 0;
  int fails = 0;

`ifdef DEMUX_TRISTATE_OUT_EN
  localparam bit TRI_EN = 1'b1;
`else
  localparam bit TRI_EN = 1'b0;
`endif

  demux_2_32_buf #(.word_size(32)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_sel(in_sel),
    .in_ready(in_ready), .data_0(data_0), .data_1(data_1), .valid_0(valid_0),
    .valid_1(valid_1), .ready_0(ready_0), .ready_1(ready_1), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected data on an empty channel
  function automatic logic [31:0] idle_exp(input logic [31:0] last);
    return TRI_EN ? 32'hzzzz_zzzz : last;
  endfunction

  task automatic release_reset();
    rst_n = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in = '0; in_valid = 0; in_sel = 0; ready_0 = 0; ready_1 = 0;
    #12;
    tests++; if (valid_0 !== 1'b0) begin fails++; $display("FAIL reset_valid_0 got %b exp 0", valid_0); end
    tests++; if (valid_1 !== 1'b0) begin fails++; $display("FAIL reset_valid_1 got %b exp 0", valid_1); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (data_0 !== idle_exp(32'h0)) begin fails++; $display("FAIL reset_data_0 got %h exp %h", data_0, idle_exp(32'h0)); end
    tests++; if (data_1 !== idle_exp(32'h0)) begin fails++; $display("FAIL reset_data_1 got %h exp %h", data_1, idle_exp(32'h0)); end
    @(posedge clk); #1;
    release_reset();
  endtask

  task automatic test_release_gate();
    rst_n = 1'b0;
    #2;
    data_in = 32'h1111_2222; in_sel = 0; in_valid = 1;
    tick();
    rst_n = 1'b1;
    tick();
    tests++; if (valid_0 !== 1'b0) begin fails++; $display("FAIL release_edge1 got %b exp 0", valid_0); end
    tick();
    tests++; if (valid_0 !== 1'b0) begin fails++; $display("FAIL release_edge2 got %b exp 0", valid_0); end
    in_valid = 0;
    tick();
  endtask

  task automatic test_single_push();
    data_in = 32'hA5A5_0001; in_sel = 0; in_valid = 1;
    tick();
    in_valid = 0;
    tests++; if (valid_0 !== 1'b1) begin fails++; $display("FAIL single_valid_0 got %b exp 1", valid_0); end
    tests++; if (data_0 !== 32'hA5A5_0001) begin fails++; $display("FAIL single_data_0 got %h exp a5a50001", data_0); end
    tests++; if (valid_1 !== 1'b0) begin fails++; $display("FAIL single_valid_1 got %b exp 0", valid_1); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b exp 1", busy); end
    ready_0 = 1;
    tick();
    ready_0 = 0;
    tests++; if (valid_0 !== 1'b0) begin fails++; $display("FAIL single_drained got %b exp 0", valid_0); end
    tests++; if (data_0 !== idle_exp(32'hA5A5_0001)) begin fails++; $display("FAIL single_idle_data got %h exp %h", data_0, idle_exp(32'hA5A5_0001)); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_off got %b exp 0", busy); end
  endtask

  task automatic test_ch1_backpressure();
    ready_1 = 0; in_sel = 1; in_valid = 1;
    data_in = 32'hB000_0001;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_w1 got %b exp 1", in_ready); end
    tick();
    data_in = 32'hB000_0002;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_w2 got %b exp 1", in_ready); end
    tick();
    data_in = 32'hB000_0003;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_w3 got %b exp 0", in_ready); end
    tick();
    tests++; if (data_1 !== 32'hB000_0001) begin fails++; $display("FAIL bp_head got %h exp b0000001", data_1); end
    tests++; if (valid_0 !== 1'b0) begin fails++; $display("FAIL bp_ch0_untouched got %b exp 0", valid_0); end
    ready_1 = 1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_pop_no_bypass got %b exp 0", in_ready); end
    tick();
    tests++; if (data_1 !== 32'hB000_0002) begin fails++; $display("FAIL bp_drain_w2 got %h exp b0000002", data_1); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_pop got %b exp 1", in_ready); end
    tick();
    in_valid = 0;
    tests++; if (data_1 !== 32'hB000_0003) begin fails++; $display("FAIL bp_drain_w3 got %h exp b0000003", data_1); end
    tests++; if (valid_1 !== 1'b1) begin fails++; $display("FAIL bp_valid_w3 got %b exp 1", valid_1); end
    tick();
    ready_1 = 0;
    tests++; if (valid_1 !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", valid_1); end
  endtask

  task automatic test_full_pop_then_push();
    ready_0 = 0; in_sel = 0; in_valid = 1;
    data_in = 32'hC000_0001; tick();
    data_in = 32'hC000_0002; tick();
    data_in = 32'hC000_0003; ready_0 = 1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    tick();
    tests++; if (data_0 !== 32'hC000_0002) begin fails++; $display("FAIL full_pop_only got %h exp c0000002", data_0); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_next got %b exp 1", in_ready); end
    tick();
    in_valid = 0;
    tests++; if (data_0 !== 32'hC000_0003) begin fails++; $display("FAIL full_push_next got %h exp c0000003", data_0); end
    tick();
    ready_0 = 0;
    tests++; if (valid_0 !== 1'b0) begin fails++; $display("FAIL full_drained got %b exp 0", valid_0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    ready_0 = 0; in_sel = 0; in_valid = 1;
    data_in = 32'hD000_0000; tick();
    ready_0 = 1;
    for (int i = 1; i < 6; i++) begin
      w = 32'hD000_0000 + 32'(i);
      data_in = w;
      tick();
      tests++; if (data_0 !== w) begin fails++; $display("FAIL b2b_word%0d got %h exp %h", i, data_0, w); end
      tests++; if (valid_0 !== 1'b1) begin fails++; $display("FAIL b2b_valid%0d got %b exp 1", i, valid_0); end
    end
    in_valid = 0;
    tick();
    ready_0 = 0;
    tests++; if (valid_0 !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b exp 0", valid_0); end
    tests++; if (data_0 !== idle_exp(32'hD000_0005)) begin fails++; $display("FAIL b2b_idle got %h exp %h", data_0, idle_exp(32'hD000_0005)); end
  endtask

  task automatic test_isolation();
    ready_0 = 0; ready_1 = 0; in_valid = 1;
    in_sel = 1; data_in = 32'hE100_0000; tick();
    in_sel = 0; data_in = 32'hE000_0000; tick();
    in_sel = 1; data_in = 32'hE100_0001; tick();
    in_valid = 0; in_sel = 0;
    tests++; if (data_0 !== 32'hE000_0000) begin fails++; $display("FAIL iso_data_0 got %h exp e0000000", data_0); end
    tests++; if (data_1 !== 32'hE100_0000) begin fails++; $display("FAIL iso_data_1 got %h exp e1000000", data_1); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL iso_ch0_ready got %b exp 1", in_ready); end
    in_sel = 1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL iso_ch1_full got %b exp 0", in_ready); end
    ready_1 = 1; tick(); ready_1 = 0;
    tests++; if (data_1 !== 32'hE100_0001) begin fails++; $display("FAIL iso_order got %h exp e1000001", data_1); end
    tests++; if (data_0 !== 32'hE000_0000) begin fails++; $display("FAIL iso_ch0_held got %h exp e0000000", data_0); end
  endtask

  task automatic test_async_reset();
    in_valid = 1; in_sel = 0; data_in = 32'hF000_0001; tick();
    in_sel = 1; data_in = 32'hF100_0002; tick();
    in_valid = 0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ar_busy_before got %b exp 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (valid_0 !== 1'b0) begin fails++; $display("FAIL ar_valid_0 got %b exp 0", valid_0); end
    tests++; if (valid_1 !== 1'b0) begin fails++; $display("FAIL ar_valid_1 got %b exp 0", valid_1); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ar_busy got %b exp 0", busy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ar_in_ready got %b exp 1", in_ready); end
    tests++; if (data_1 !== idle_exp(32'h0)) begin fails++; $display("FAIL ar_data_1 got %h exp %h", data_1, idle_exp(32'h0)); end
    tick();
    release_reset();
    in_valid = 1; in_sel = 0; data_in = 32'h5A5A_0007; tick();
    in_valid = 0;
    tests++; if (data_0 !== 32'h5A5A_0007) begin fails++; $display("FAIL ar_first_word got %h exp 5a5a0007", data_0); end
    tests++; if (valid_1 !== 1'b0) begin fails++; $display("FAIL ar_ch1_discarded got %b exp 0", valid_1); end
  endtask

  initial begin
    test_reset();
    test_release_gate();
    test_single_push();
    test_ch1_backpressure();
    test_full_pop_then_push();
    test_back_to_back();
    test_isolation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
